mdu_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations in the execute stage of the pipelined core. It accepts one M-extension operation at a time from the execute stage and runs an iterative shift-add multiply or restoring divide over XLEN cycles. While an operation is in flight it holds the pipeline through a stall output, then presents the result for one cycle. The base ALU and its decoder continue to handle all non-M operations.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_sequencer_if.sv | 26 ++
 rtl/mdu_iter_step.sv | 43 ++++
 rtl/mdu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the RV32M multiply/divide sequencer.
// Holds the sequencer state enum, the funct3 op codes and the iteration counter width.
// Helper functions decode operand signedness and take two's-complement magnitudes.
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // {rs1 is signed, rs2 is signed} for a given op. MUL is treated as unsigned:
    // the low half of the product does not depend on operand signedness.
    function automatic logic [1:0] op_signs(input logic [2:0] f3);
        logic a_s;
        logic b_s;
        a_s = (f3 == MDU_MULH) || (f3 == MDU_MULHSU) || (f3 == MDU_DIV) || (f3 == MDU_REM);
        b_s = (f3 == MDU_MULH) || (f3 == MDU_DIV) || (f3 == MDU_REM);
        return {a_s, b_s};
    endfunction

    // Magnitude of v when it is to be read as negative; the most-negative value
    // maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: execute-stage <-> multiply/divide sequencer handshake bundle.
// master = execute stage (drives start/funct3/rs1/rs2/flush, sees stall/done/result).
// slave  = sequencer (the reverse directions).
interface mdu_sequencer_if;
    import mdu_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output stall, done, result
    );

endinterface

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one iteration of shift-add multiply or restoring divide.
// Latency: purely combinational. Backpressure: none, evaluated every RUN cycle.
// Ports: is_div selects divide; hi/lo are the accumulator halves; mag is the
//   multiplicand or divisor magnitude; hi_nxt/lo_nxt are the updated halves.
module mdu_iter_step
    import mdu_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] mag,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        hi_nxt  = hi;
        lo_nxt  = lo;
        // Multiply: lo holds the remaining multiplier bits, hi the partial product.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
        // Divide: hi is the partial remainder, lo shifts the dividend out and
        // the quotient in. Since hi < mag, a set top bit of diff means borrow.
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, mag};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide sequencer for the execute stage.
// Latency: XLEN+3 cycles from accepted start to done; divide-by-zero and signed
//   overflow finish in 1 cycle, as do all multiplies when MDU_FAST_MUL_EN is defined.
// Backpressure: stall holds IF/ID/EX while busy; start is sampled only in IDLE.
// Ports: clk, rst (async, active-high), bus (mdu_sequencer_if.slave: start, funct3,
//   rs1, rs2, flush in; stall, done, result out).
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mdu_sequencer_if.slave bus
);

    mdu_state_t       state;
    mdu_state_t       state_nxt;
    logic             stall_c;
    logic             done_c;

    logic [2:0]       f3;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [XLEN-1:0]  mag;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  result_q;

    logic [XLEN-1:0]  step_hi;
    logic [XLEN-1:0]  step_lo;

    // ---------------- acceptance and single-cycle shortcuts ----------------
    logic             accept;
    logic             in_div_zero;
    logic             in_ovf;
    logic             fast_hit;
    logic [XLEN-1:0]  fast_res;
    logic             bypass;
    logic [XLEN-1:0]  bypass_res;

    // A flush in the same cycle drops the start entirely.
    assign accept      = (state == ST_IDLE) && bus.start && !bus.flush;
    assign in_div_zero = bus.funct3[2] && (bus.rs2 == '0);
    // Signed DIV/REM only (funct3[0] clear), most-negative / -1.
    assign in_ovf      = bus.funct3[2] && !bus.funct3[0]
                         && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);

`ifdef MDU_FAST_MUL_EN
    logic [1:0]        in_sgn;
    logic [2*XLEN-1:0] fast_a;
    logic [2*XLEN-1:0] fast_b;
    logic [2*XLEN-1:0] fast_p;

    // Sign-extend to the full product width so a plain modular multiply
    // yields the correct signed/unsigned product in all 2*XLEN bits.
    always_comb begin
        in_sgn = op_signs(bus.funct3);
        fast_a = {{XLEN{in_sgn[1] & bus.rs1[XLEN-1]}}, bus.rs1};
        fast_b = {{XLEN{in_sgn[0] & bus.rs2[XLEN-1]}}, bus.rs2};
        fast_p = fast_a * fast_b;
    end

    assign fast_hit = !bus.funct3[2];
    assign fast_res = (bus.funct3 == MDU_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    assign bypass = in_div_zero || in_ovf || fast_hit;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        bypass_res = fast_res;
        if (in_div_zero) begin
            bypass_res = bus.funct3[1] ? bus.rs1 : '1;
        end else if (in_ovf) begin
            bypass_res = bus.funct3[1] ? '0 : bus.rs1;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nxt = bypass ? ST_DONE : ST_PREP;
            ST_PREP: state_nxt = ST_RUN;
            ST_RUN:  if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end
        // Low in DONE so EX captures result on the done cycle. Reset forces it
        // low immediately even if start is still asserted.
        stall_c = !rst && (accept || (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX));
        done_c  = (state == ST_DONE);
    end

    assign bus.stall  = stall_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;

    // ---------------- datapath ----------------
    logic [1:0]        sgn;
    logic              neg_a;
    logic              neg_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    assign sgn   = op_signs(f3);
    assign neg_a = sgn[1] & op_a[XLEN-1];
    assign neg_b = sgn[0] & op_b[XLEN-1];

    mdu_iter_step u_step (
        .is_div (f3[2]),
        .hi     (hi),
        .lo     (lo),
        .mag    (mag),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    // Sign fix-up on the unsigned magnitude result: product and quotient are
    // negated when operand signs differ; remainder follows the dividend.
    always_comb begin
        prod    = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
        quo     = (neg_a ^ neg_b) ? -lo : lo;
        rem     = neg_a ? -hi : hi;
        fix_res = rem;
        case (f3)
            MDU_MUL:                         fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fix_res = quo;
            default:                         fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            hi       <= '0;
            lo       <= '0;
            mag      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3   <= bus.funct3;
                        op_a <= bus.rs1;
                        op_b <= bus.rs2;
                        if (bypass) begin
                            result_q <= bypass_res;
                        end
                    end
                end
                ST_PREP: begin
                    // Multiply: lo = multiplier, mag = multiplicand.
                    // Divide:   lo = dividend,   mag = divisor.
                    hi  <= '0;
                    lo  <= f3[2] ? mag_of(op_a, neg_a) : mag_of(op_b, neg_b);
                    mag <= f3[2] ? mag_of(op_b, neg_b) : mag_of(op_a, neg_a);
                    cnt <= CNT_W'(XLEN - 1);
                end
                ST_RUN: begin
                    hi <= step_hi;
                    lo <= step_lo;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.flush) begin
                        result_q <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer.
// The driver pushes the expected result and latency of each op into a queue;
// a monitor pops and compares on every done pulse.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          issue;
        string       name;
    } exp_t;

    exp_t sb[$];

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on 32/64-bit values.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (f)
            MDU_MUL:    begin p = longint'($signed(a)) * longint'($signed(b)); r = p[31:0]; end
            MDU_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
            MDU_MULHSU: begin p = longint'($signed(a)) * longint'({32'b0, b}); r = p[63:32]; end
            MDU_MULHU:  begin p = {32'b0, a} * {32'b0, b};                     r = p[63:32]; end
            MDU_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            MDU_REM:    r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            MDU_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:    r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == MDU_DIV || f == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 35;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 result=0x%08h expected no done (t=%0t)",
                             bus.result, $time);
                end else begin
                    m = sb.pop_front();
                    check({m.name, "_result"}, bus.result, m.res);
                    check({m.name, "_latency"}, 32'(cyc - m.issue), 32'(m.lat));
                end
            end
        end
    end

    // Issue one op in the current IDLE cycle (called at a negedge) and wait for it.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        exp_t e;
        int   n;
        bit   busy_ok;
        e.res   = ref_res(f, a, b);
        e.lat   = exp_lat(f, a, b);
        e.issue = cyc;
        e.name  = name;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.rs1    = a;
        bus.rs2    = b;
        #1;
        check({name, "_stall0"}, 32'(bus.stall), 32'd1);
        @(negedge clk);
        // Scramble inputs: the op must already be latched.
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.rs1    = $urandom;
        bus.rs2    = $urandom;
        busy_ok = 1'b1;
        n = 1;
        while (!bus.done && n < 200) begin
            if (!bus.stall) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        check({name, "_busy_stall"}, 32'(busy_ok), 32'd1);
        check({name, "_done_stall"}, 32'(bus.stall), 32'd0);
        if (bus.done) last_res = e.res;
        else sb.delete();
        @(negedge clk);
        check({name, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(bus.done), 32'd1);
        if (!bus.done) sb.delete();
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("mul_7_m3",    MDU_MUL,   32'd7,          32'hFFFF_FFFD);
        run_op("mulhu_ff",    MDU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mulh_ff",     MDU_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mulhsu_m1",   MDU_MULHSU,32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("div_m7_2",    MDU_DIV,   32'hFFFF_FFF9,  32'd2);
        run_op("rem_m7_2",    MDU_REM,   32'hFFFF_FFF9,  32'd2);
        run_op("divu_100_7",  MDU_DIVU,  32'd100,        32'd7);
        run_op("remu_100_7",  MDU_REMU,  32'd100,        32'd7);
        run_op("div_5_0",     MDU_DIV,   32'd5,          32'd0);
        run_op("rem_5_0",     MDU_REM,   32'd5,          32'd0);
        run_op("div_ovf",     MDU_DIV,   32'h8000_0000,  32'hFFFF_FFFF);
        run_op("rem_ovf",     MDU_REM,   32'h8000_0000,  32'hFFFF_FFFF);
        run_op("divu_min_m1", MDU_DIVU,  32'h8000_0000,  32'hFFFF_FFFF);

        // start held through DONE: re-accepted only in the following IDLE cycle
        e1.res   = ref_res(MDU_DIVU, 32'd1000, 32'd3);
        e1.lat   = 35;
        e1.issue = cyc;
        e1.name  = "held_first";
        e2       = e1;
        e2.issue = cyc + 36;
        e2.name  = "held_second";
        sb.push_back(e1);
        sb.push_back(e2);
        bus.start  = 1'b1;
        bus.funct3 = MDU_DIVU;
        bus.rs1    = 32'd1000;
        bus.rs2    = 32'd3;
        @(negedge clk);
        wait_done("held_first");
        check("held_done_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        check("held_reaccept_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.rs1   = $urandom;
        wait_done("held_second");
        last_res = e1.res;
        @(negedge clk);

        // flush in cycle 10 of a DIVU
        bus.start  = 1'b1;
        bus.funct3 = MDU_DIVU;
        bus.rs1    = 32'd12345;
        bus.rs2    = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_idle_stall", 32'(bus.stall), 32'd0);
        check("flush_result_kept", bus.result, last_res);
        repeat (40) @(negedge clk);
        check("flush_result_later", bus.result, last_res);

        // flush together with start in IDLE drops the start
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = MDU_DIV;
        bus.rs1    = 32'd9;
        bus.rs2    = 32'd0;
        #1;
        check("flush_start_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_dropped", 32'(bus.stall), 32'd0);
        repeat (5) @(negedge clk);
        check("flush_start_result", bus.result, last_res);

        run_op("after_flush", MDU_DIVU, 32'd12345, 32'd7);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), pick(), pick());
        end

        // Reset mid-RUN
        bus.start  = 1'b1;
        bus.funct3 = MDU_DIV;
        bus.rs1    = 32'hDEAD_BEEF;
        bus.rs2    = 32'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(bus.stall), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);
        run_op("after_rst", MDU_MUL, 32'd7, 32'hFFFF_FFFD);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
